// File: rtl/alu_sequencer_if.sv
// Handshake and result/flag bus between the ALU sequencer and its client.
// master: drives start/op/operands/carry, receives busy/done/result/flag strobes.
// slave:  the ALU sequencer side.
`timescale 1ns/1ps
interface alu_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] f_in;
    logic             c_cur;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             z_wr_en;
    logic             z_in;
    logic             dc_wr_en;
    logic             dc_in;
    logic             c_wr_en;
    logic             c_in;

    modport master (
        output start, op, w_in, f_in, c_cur,
        input  busy, done, result, z_wr_en, z_in, dc_wr_en, dc_in, c_wr_en, c_in
    );

    modport slave (
        input  start, op, w_in, f_in, c_cur,
        output busy, done, result, z_wr_en, z_in, dc_wr_en, dc_in, c_wr_en, c_in
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle PIC16F ALU stage: latches W/F/op/C on start, computes in Q1,
// and presents result plus per-flag Z/DC/C write strobes to STATUS in Q4.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-low
//   bus  - alu_sequencer_if.slave (start/op/w_in/f_in/c_cur in;
//          busy/done/result and Z/DC/C enable+data out)
`timescale 1ns/1ps
module alu_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_sequencer_if.slave      bus
);
    localparam int unsigned HALF = WIDTH / 2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_IOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_COM  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_RLF  = 4'd8;
    localparam logic [3:0] OP_RRF  = 4'd9;
    localparam logic [3:0] OP_SWAP = 4'd10;
    localparam logic [3:0] OP_MOVF = 4'd11;
    localparam logic [3:0] OP_CLR  = 4'd12;
    localparam logic [3:0] OP_MOVW = 4'd13;

    typedef enum logic [2:0] {IDLE, Q1, Q2, Q3, Q4} state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] f_q;
    logic             cin_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q;
    logic             dc_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             z_en_q;
    logic             dc_en_q;
    logic             c_en_q;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] res_c;
    logic             dc_c;
    logic             cf_c;
    logic             z_aff_c;
    logic             dc_aff_c;
    logic             c_aff_c;

    // Datapath and flag-affect decode from the latched operands.
    // DC is recovered as the carry into bit 4: sum[4] ^ a[4] ^ b[4].
    always_comb begin
        sum_c    = {1'b0, f_q} + {1'b0, w_q};
        diff_c   = {1'b0, f_q} + {1'b0, ~w_q} + (WIDTH+1)'(1);
        res_c    = f_q;
        dc_c     = 1'b0;
        cf_c     = 1'b0;
        z_aff_c  = 1'b0;
        dc_aff_c = 1'b0;
        c_aff_c  = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_c    = sum_c[WIDTH-1:0];
                cf_c     = sum_c[WIDTH];
                dc_c     = sum_c[4] ^ f_q[4] ^ w_q[4];
                z_aff_c  = 1'b1;
                dc_aff_c = 1'b1;
                c_aff_c  = 1'b1;
            end
            OP_SUB: begin
                res_c    = diff_c[WIDTH-1:0];
                cf_c     = diff_c[WIDTH];
                dc_c     = diff_c[4] ^ f_q[4] ^ ~w_q[4];
                z_aff_c  = 1'b1;
                dc_aff_c = 1'b1;
                c_aff_c  = 1'b1;
            end
            OP_AND:  begin res_c = f_q & w_q;            z_aff_c = 1'b1; end
            OP_IOR:  begin res_c = f_q | w_q;            z_aff_c = 1'b1; end
            OP_XOR:  begin res_c = f_q ^ w_q;            z_aff_c = 1'b1; end
            OP_COM:  begin res_c = ~f_q;                 z_aff_c = 1'b1; end
            OP_INC:  begin res_c = f_q + WIDTH'(1);      z_aff_c = 1'b1; end
            OP_DEC:  begin res_c = f_q - WIDTH'(1);      z_aff_c = 1'b1; end
            OP_RLF: begin
                res_c   = {f_q[WIDTH-2:0], cin_q};
                cf_c    = f_q[WIDTH-1];
                c_aff_c = 1'b1;
            end
            OP_RRF: begin
                res_c   = {cin_q, f_q[WIDTH-1:1]};
                cf_c    = f_q[0];
                c_aff_c = 1'b1;
            end
            OP_SWAP: res_c = {f_q[HALF-1:0], f_q[WIDTH-1:HALF]};
            OP_MOVF: begin res_c = f_q;                  z_aff_c = 1'b1; end
            OP_CLR:  begin res_c = '0;                   z_aff_c = 1'b1; end
            OP_MOVW: res_c = w_q;
            default: res_c = f_q;
        endcase
    end

    // Q1..Q4 sequencer; done/strobes are loaded on Q3->Q4 so they pulse in Q4 only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            w_q      <= '0;
            f_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            dc_q     <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            z_en_q   <= 1'b0;
            dc_en_q  <= 1'b0;
            c_en_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        w_q    <= bus.w_in;
                        f_q    <= bus.f_in;
                        cin_q  <= bus.c_cur;
                        busy_q <= 1'b1;
                        state  <= Q1;
                    end
                end
                Q1: begin
                    result_q <= res_c;
                    z_q      <= (res_c == '0);
                    dc_q     <= dc_c;
                    c_q      <= cf_c;
                    state    <= Q2;
                end
                Q2: state <= Q3;
                Q3: begin
                    done_q  <= 1'b1;
                    z_en_q  <= z_aff_c;
                    dc_en_q <= dc_aff_c;
                    c_en_q  <= c_aff_c;
                    state   <= Q4;
                end
                Q4: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    z_en_q  <= 1'b0;
                    dc_en_q <= 1'b0;
                    c_en_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.z_wr_en  = z_en_q;
    assign bus.z_in     = z_q;
    assign bus.dc_wr_en = dc_en_q;
    assign bus.dc_in    = dc_q;
    assign bus.c_wr_en  = c_en_q;
    assign bus.c_in     = c_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: opcode/flag vectors, back-to-back
// start, operand latching and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_alu_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs in Q1, check busy window and Q4 outputs.
    // een/efl are {Z, DC, C}; flag data is checked only where enabled.
    task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] w,
                          input logic [7:0] f, input logic c, input logic [7:0] er,
                          input logic [2:0] een, input logic [2:0] efl);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.w_in = w; bus.f_in = f; bus.c_cur = c;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0; bus.w_in = ~w; bus.f_in = ~f; bus.c_cur = ~c;
            end
            check({name, ".busy"}, 8'(bus.busy), 8'(n <= 4));
            check({name, ".done"}, 8'(bus.done), 8'(n == 4));
            if (n == 4) begin
                check({name, ".result"}, bus.result, er);
                check({name, ".en"}, 8'({bus.z_wr_en, bus.dc_wr_en, bus.c_wr_en}), 8'(een));
                if (een[2]) check({name, ".z"},  8'(bus.z_in),  8'(efl[2]));
                if (een[1]) check({name, ".dc"}, 8'(bus.dc_in), 8'(efl[1]));
                if (een[0]) check({name, ".c"},  8'(bus.c_in),  8'(efl[0]));
            end
            if (n == 5) begin
                check({name, ".en_idle"}, 8'({bus.z_wr_en, bus.dc_wr_en, bus.c_wr_en}), 8'd0);
                check({name, ".hold"}, bus.result, er);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.op = 4'd0; bus.w_in = 8'h00; bus.f_in = 8'h00; bus.c_cur = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy",   8'(bus.busy), 8'd0);
        check("reset.done",   8'(bus.done), 8'd0);
        check("reset.result", bus.result,   8'h00);
        check("reset.en", 8'({bus.z_wr_en, bus.dc_wr_en, bus.c_wr_en}), 8'd0);
        rst = 1'b1;

        run_op("add_0f_01",  4'd0,  8'h01, 8'h0F, 1'b0, 8'h10, 3'b111, 3'b010);
        run_op("add_ff_01",  4'd0,  8'h01, 8'hFF, 1'b0, 8'h00, 3'b111, 3'b111);
        run_op("sub_03_05",  4'd1,  8'h05, 8'h03, 1'b0, 8'hFE, 3'b111, 3'b000);
        run_op("sub_05_05",  4'd1,  8'h05, 8'h05, 1'b0, 8'h00, 3'b111, 3'b111);
        run_op("rlf_80",     4'd8,  8'h00, 8'h80, 1'b0, 8'h00, 3'b001, 3'b001);
        run_op("rrf_01",     4'd9,  8'h00, 8'h01, 1'b1, 8'h80, 3'b001, 3'b001);
        run_op("and",        4'd2,  8'h0F, 8'hF0, 1'b0, 8'h00, 3'b100, 3'b100);
        run_op("ior",        4'd3,  8'h0F, 8'hF0, 1'b0, 8'hFF, 3'b100, 3'b000);
        run_op("xor",        4'd4,  8'hFF, 8'h5A, 1'b0, 8'hA5, 3'b100, 3'b000);
        run_op("com",        4'd5,  8'h00, 8'hFF, 1'b0, 8'h00, 3'b100, 3'b100);
        run_op("inc_ff",     4'd6,  8'h00, 8'hFF, 1'b0, 8'h00, 3'b100, 3'b100);
        run_op("swap",       4'd10, 8'h00, 8'hA5, 1'b0, 8'h5A, 3'b000, 3'b000);
        run_op("movf",       4'd11, 8'h33, 8'h42, 1'b0, 8'h42, 3'b100, 3'b000);
        run_op("clr",        4'd12, 8'h12, 8'h34, 1'b0, 8'h00, 3'b100, 3'b100);
        run_op("movw",       4'd13, 8'h77, 8'h34, 1'b0, 8'h77, 3'b000, 3'b000);
        run_op("rsvd14",     4'd14, 8'h77, 8'h34, 1'b0, 8'h34, 3'b000, 3'b000);

        // Start held high: one op per 5 cycles; W changed in Q1 must not affect op 1.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.w_in = 8'h01; bus.f_in = 8'h02; bus.c_cur = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) bus.w_in = 8'h10;
            check("cont.done", 8'(bus.done), 8'(n % 5 == 4));
            check("cont.busy", 8'(bus.busy), 8'(n % 5 != 0));
            if (n == 4) check("cont.result1", bus.result, 8'h03);
            if (n == 9) check("cont.result2", bus.result, 8'h12);
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in Q2 of an ADD.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.w_in = 8'h01; bus.f_in = 8'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("q2.result_pre", bus.result, 8'h10);
        #2 rst = 1'b0;
        #1;
        check("arst.busy",   8'(bus.busy), 8'd0);
        check("arst.done",   8'(bus.done), 8'd0);
        check("arst.en", 8'({bus.z_wr_en, bus.dc_wr_en, bus.c_wr_en}), 8'd0);
        check("arst.result", bus.result,   8'h00);
        @(negedge clk);
        rst = 1'b1;
        run_op("dec_00", 4'd7, 8'h00, 8'h00, 1'b0, 8'hFF, 3'b100, 3'b000);

        // Asynchronous reset in Q4 suppresses the flag write.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd0; bus.w_in = 8'h01; bus.f_in = 8'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("q4.z_en_pre", 8'(bus.z_wr_en), 8'd1);
        #2 rst = 1'b0;
        #1;
        check("q4rst.en", 8'({bus.z_wr_en, bus.dc_wr_en, bus.c_wr_en}), 8'd0);
        check("q4rst.done", 8'(bus.done), 8'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("after_q4rst", 4'd6, 8'h00, 8'h41, 1'b0, 8'h42, 3'b100, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
